// File: rtl/mbc6_cart_reader.sv
// MBC6 cart-bus initiator: enables cart RAM, selects a 4KB bank, reads a run of bytes
// from $A000-$AFFF and streams them over valid/ready. Optional checksum: MBC6_CART_READER_CHECKSUM_EN.
module mbc6_cart_reader #(
  parameter int RD_WAIT = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  ram_bank,
  input  logic [11:0] start_offset,
  input  logic [11:0] length,
  output logic        busy,
  output logic        done,
  output logic [15:0] cart_addr,
  output logic        cart_wr,
  output logic        cart_rd,
  output logic [7:0]  cart_do,
  input  logic [7:0]  cart_di,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready
`ifdef MBC6_CART_READER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_EN   = 3'd1;
  localparam logic [2:0] WR_BANK = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] OUT     = 3'd4;
  localparam logic [2:0] WR_DIS  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT - 1);

  logic [2:0]  state;
  logic [2:0]  bank_q;
  logic [11:0] offset_q;
  logic [11:0] remaining_q;
  logic [1:0]  wait_cnt;

  logic abort_hit;
  logic accept;
  logic enter_dis;

  // Abort only matters while the run is still reading; after that the disable write must finish.
  assign abort_hit = abort && (state == WR_EN || state == WR_BANK || state == RD_ADDR || state == OUT);
  assign accept    = (state == OUT) && data_ready && !abort;
  assign enter_dis = abort_hit || (accept && remaining_q == 12'd0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cart_addr   <= 16'h0000;
      cart_wr     <= 1'b0;
      cart_rd     <= 1'b0;
      cart_do     <= 8'h00;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      bank_q      <= 3'd0;
      offset_q    <= 12'd0;
      remaining_q <= 12'd0;
      wait_cnt    <= 2'd0;
    end else begin
      done <= 1'b0;
      if (enter_dis) begin
        cart_addr  <= 16'h0000;
        cart_do    <= 8'h00;
        cart_wr    <= 1'b1;
        cart_rd    <= 1'b0;
        data_valid <= 1'b0;
        state      <= WR_DIS;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              bank_q      <= ram_bank;
              offset_q    <= start_offset;
              remaining_q <= length;
              busy        <= 1'b1;
              cart_addr   <= 16'h0000;
              cart_do     <= 8'h0A;
              cart_wr     <= 1'b1;
              state       <= WR_EN;
            end
          end
          WR_EN: begin
            if (ce_cpu) begin
              cart_addr <= 16'h0400;
              cart_do   <= {5'b0, bank_q};
              state     <= WR_BANK;
            end
          end
          WR_BANK: begin
            if (ce_cpu) begin
              cart_wr   <= 1'b0;
              cart_rd   <= 1'b1;
              cart_do   <= 8'h00;
              cart_addr <= {4'hA, offset_q};
              wait_cnt  <= 2'd0;
              state     <= RD_ADDR;
            end
          end
          RD_ADDR: begin
            if (ce_cpu) begin
              if (wait_cnt == WAIT_LAST) begin
                data_out   <= cart_di;
                data_valid <= 1'b1;
                cart_rd    <= 1'b0;
                state      <= OUT;
              end else begin
                wait_cnt <= wait_cnt + 2'd1;
              end
            end
          end
          OUT: begin
            // The 12-bit offset wraps naturally, keeping every read inside the $A000 window.
            if (accept) begin
              data_valid  <= 1'b0;
              offset_q    <= offset_q + 12'd1;
              remaining_q <= remaining_q - 12'd1;
              cart_addr   <= {4'hA, offset_q + 12'd1};
              cart_rd     <= 1'b1;
              wait_cnt    <= 2'd0;
              state       <= RD_ADDR;
            end
          end
          WR_DIS: begin
            if (ce_cpu) begin
              cart_wr <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MBC6_CART_READER_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 16'h0000;
    end else if (state == IDLE && start) begin
      checksum <= 16'h0000;
    end else if (accept) begin
      checksum <= checksum + {8'h00, data_out};
    end
  end
`endif

endmodule

// File: tb/tb_mbc6_cart_reader.sv
// Directed self-checking bench for mbc6_cart_reader; a bus monitor logs completed cart ops
// and accepted bytes, which are compared against hand-built expectations.
module tb_mbc6_cart_reader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_cpu = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  ram_bank = 3'd0;
  logic [11:0] start_offset = 12'd0;
  logic [11:0] length = 12'd0;
  logic        busy, done, cart_wr, cart_rd, data_valid;
  logic [15:0] cart_addr;
  logic [7:0]  cart_do, cart_di, data_out;
  logic        data_ready = 1'b1;
`ifdef MBC6_CART_READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_checks = 0;
  int n_fail = 0;

  int ce_div = 1;
  int ce_phase = 0;
  int ready_mode = 0;
  int stall_cnt = 0;
  logic ff_mode = 1'b0;
  logic stab_en = 1'b0;

  logic [31:0] log_q[$];
  logic [7:0]  rx_q[$];
  int done_cnt = 0, rd_rise = 0, stab_viol = 0, hold_viol = 0;
  int log_base = 0, rx_base = 0, done_base = 0, rd_base = 0;
  logic [31:0] exp_log[$];
  logic [7:0]  exp_rx[$];

  logic        prev_rd = 1'b0, prev_strobe = 1'b0, prev_ce = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0]  prev_dout = 8'h00;
  logic [25:0] prev_bus = '0;

  mbc6_cart_reader #(.RD_WAIT(1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .start(start), .abort(abort),
    .ram_bank(ram_bank), .start_offset(start_offset), .length(length),
    .busy(busy), .done(done), .cart_addr(cart_addr), .cart_wr(cart_wr), .cart_rd(cart_rd),
    .cart_do(cart_do), .cart_di(cart_di), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready)
`ifdef MBC6_CART_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Cart model: RAM byte equals the address low byte, or $FF in ff_mode.
  assign cart_di = ff_mode ? 8'hFF : cart_addr[7:0];

  always @(posedge clk_sys) begin
    #1;
    ce_phase = ce_phase + 1;
    ce_cpu = ((ce_phase % ce_div) == 0);
  end

  always @(posedge clk_sys) begin
    #1;
    case (ready_mode)
      1: begin
        if ((rx_q.size() - rx_base) == 1 && data_valid && stall_cnt < 10) begin
          data_ready = 1'b0;
          stall_cnt = stall_cnt + 1;
        end else begin
          data_ready = 1'b1;
        end
      end
      2: data_ready = ((rx_q.size() - rx_base) != 1);
      default: data_ready = 1'b1;
    endcase
  end

  function automatic logic [31:0] enc(logic rd, logic wr, logic [15:0] a, logic [7:0] d);
    return {6'd0, rd, wr, a, d};
  endfunction

  // Inputs change at posedge+1, so values seen at negedge are what the next posedge samples.
  always @(negedge clk_sys) begin
    if (ce_cpu && (cart_wr || cart_rd))
      log_q.push_back(enc(cart_rd, cart_wr, cart_addr, cart_rd ? 8'h00 : cart_do));
    if (data_valid && data_ready) rx_q.push_back(data_out);
    if (done) done_cnt = done_cnt + 1;
    if (cart_rd && !prev_rd) rd_rise = rd_rise + 1;
    if (stab_en) begin
      if (prev_strobe && !prev_ce && {cart_rd, cart_wr, cart_addr, cart_do} != prev_bus)
        stab_viol = stab_viol + 1;
      if (prev_valid && !prev_ready && (!data_valid || data_out != prev_dout))
        hold_viol = hold_viol + 1;
    end
    prev_rd     = cart_rd;
    prev_strobe = cart_rd || cart_wr;
    prev_ce     = ce_cpu;
    prev_bus    = {cart_rd, cart_wr, cart_addr, cart_do};
    prev_valid  = data_valid;
    prev_ready  = data_ready;
    prev_dout   = data_out;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks = n_checks + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic beginRun();
    exp_log.delete();
    exp_rx.delete();
    log_base  = log_q.size();
    rx_base   = rx_q.size();
    done_base = done_cnt;
    rd_base   = rd_rise;
  endtask

  task automatic expWr(input logic [15:0] a, input logic [7:0] d);
    exp_log.push_back(enc(1'b0, 1'b1, a, d));
  endtask

  task automatic expRd(input logic [15:0] a);
    exp_log.push_back(enc(1'b1, 1'b0, a, 8'h00));
  endtask

  task automatic applyStimulus(input logic [2:0] bank, input logic [11:0] off,
                               input logic [11:0] len, input logic with_abort);
    @(posedge clk_sys); #1;
    ram_bank = bank; start_offset = off; length = len;
    start = 1'b1; abort = with_abort;
    @(posedge clk_sys); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk_sys);
      if (done) break;
    end
    if (k == budget) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk_sys);
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  task automatic verifyRun(input string tag);
    int nl, nr;
    nl = log_q.size() - log_base;
    nr = rx_q.size() - rx_base;
    checkOutput({tag, "_ops"}, 32'(nl), 32'(exp_log.size()));
    for (int i = 0; i < nl && i < exp_log.size(); i++)
      checkOutput($sformatf("%s_op%0d", tag, i), log_q[log_base + i], exp_log[i]);
    checkOutput({tag, "_bytes"}, 32'(nr), 32'(exp_rx.size()));
    for (int i = 0; i < nr && i < exp_rx.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base + i]), 32'(exp_rx[i]));
    checkOutput({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  initial begin
    int k;
    int sv0, hv0;

    repeat (2) @(negedge clk_sys);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr", 32'(cart_wr), 32'd0);
    checkOutput("rst_rd", 32'(cart_rd), 32'd0);
    checkOutput("rst_addr", 32'(cart_addr), 32'h0000);
    checkOutput("rst_do", 32'(cart_do), 32'h00);
    checkOutput("rst_valid", 32'(data_valid), 32'd0);
    checkOutput("rst_dout", 32'(data_out), 32'h00);
`ifdef MBC6_CART_READER_CHECKSUM_EN
    checkOutput("rst_csum", 32'(checksum), 32'h0000);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Basic run, abort presented together with start (start wins).
    beginRun();
    expWr(16'h0000, 8'h0A); expWr(16'h0400, 8'h02);
    for (int i = 0; i < 4; i++) begin
      expRd(16'hA010 + 16'(i));
      exp_rx.push_back(8'h10 + 8'(i));
    end
    expWr(16'h0000, 8'h00);
    applyStimulus(3'd2, 12'h010, 12'd3, 1'b1);
    waitDone("basic", 200);
    verifyRun("basic");

    // Offset wrap; a second start mid-run must be ignored.
    beginRun();
    expWr(16'h0000, 8'h0A); expWr(16'h0400, 8'h01);
    expRd(16'hAFFE); expRd(16'hAFFF); expRd(16'hA000);
    exp_rx.push_back(8'hFE); exp_rx.push_back(8'hFF); exp_rx.push_back(8'h00);
    expWr(16'h0000, 8'h00);
    applyStimulus(3'd1, 12'hFFE, 12'd2, 1'b0);
    @(posedge clk_sys); #1;
    ram_bank = 3'd7; start_offset = 12'h555; length = 12'd9; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    waitDone("wrap", 200);
    verifyRun("wrap");

    // Slow ce_cpu with a 10-cycle consumer stall on the 2nd byte.
    ce_div = 4; ready_mode = 1; stab_en = 1'b1;
    sv0 = stab_viol; hv0 = hold_viol;
    beginRun();
    expWr(16'h0000, 8'h0A); expWr(16'h0400, 8'h03);
    for (int i = 0; i < 3; i++) begin
      expRd(16'hA020 + 16'(i));
      exp_rx.push_back(8'h20 + 8'(i));
    end
    expWr(16'h0000, 8'h00);
    applyStimulus(3'd3, 12'h020, 12'd2, 1'b0);
    waitDone("slow", 600);
    verifyRun("slow");
    checkOutput("slow_rd_count", 32'(rd_rise - rd_base), 32'd3);
    checkOutput("slow_stall", 32'(stall_cnt), 32'd10);
    checkOutput("slow_bus_stable", 32'(stab_viol - sv0), 32'd0);
    checkOutput("slow_data_hold", 32'(hold_viol - hv0), 32'd0);
    stab_en = 1'b0; ready_mode = 0; ce_div = 1;

    // Abort in OUT on the 2nd byte of a 5-byte run.
    ready_mode = 2;
    beginRun();
    expWr(16'h0000, 8'h0A); expWr(16'h0400, 8'h00);
    expRd(16'hA030); expRd(16'hA031);
    exp_rx.push_back(8'h30);
    expWr(16'h0000, 8'h00);
    applyStimulus(3'd0, 12'h030, 12'd4, 1'b0);
    for (k = 0; k < 100; k++) begin
      @(negedge clk_sys);
      if ((rx_q.size() - rx_base) == 1 && data_valid && !data_ready) break;
    end
    if (k == 100) checkOutput("abort_reach_out", 32'd0, 32'd1);
    abort = 1'b1;
    @(posedge clk_sys); #1;
    abort = 1'b0;
    checkOutput("abort_valid_drop", 32'(data_valid), 32'd0);
    checkOutput("abort_dis_wr", 32'(cart_wr), 32'd1);
    waitDone("abort", 100);
    verifyRun("abort");
    ready_mode = 0;

    // Asynchronous reset while a read is on the bus.
    ce_div = 4;
    applyStimulus(3'd4, 12'h200, 12'd7, 1'b0);
    for (k = 0; k < 200; k++) begin
      @(negedge clk_sys);
      if (cart_rd) break;
    end
    if (k == 200) checkOutput("rst_reach_rd", 32'd0, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_rd", 32'(cart_rd), 32'd0);
    checkOutput("arst_wr", 32'(cart_wr), 32'd0);
    checkOutput("arst_addr", 32'(cart_addr), 32'h0000);
    checkOutput("arst_valid", 32'(data_valid), 32'd0);
    beginRun();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    checkOutput("arst_no_ops", 32'(log_q.size() - log_base), 32'd0);
    ce_div = 1;
    beginRun();
    expWr(16'h0000, 8'h0A); expWr(16'h0400, 8'h05);
    expRd(16'hA142); exp_rx.push_back(8'h42);
    expWr(16'h0000, 8'h00);
    applyStimulus(3'd5, 12'h142, 12'd0, 1'b0);
    waitDone("post_rst", 200);
    verifyRun("post_rst");

`ifdef MBC6_CART_READER_CHECKSUM_EN
    // 258 bytes of $FF: 258*255 = 65790, which wraps to $00FE.
    ff_mode = 1'b1;
    beginRun();
    applyStimulus(3'd6, 12'h000, 12'd257, 1'b0);
    waitDone("csum", 3000);
    checkOutput("csum_bytes", 32'(rx_q.size() - rx_base), 32'd258);
    checkOutput("csum_wrap", 32'(checksum), 32'h00FE);
    ff_mode = 1'b0;
    applyStimulus(3'd0, 12'h005, 12'd0, 1'b0);
    checkOutput("csum_clear", 32'(checksum), 32'h0000);
    waitDone("csum2", 200);
    checkOutput("csum_second", 32'(checksum), 32'h0005);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
